// File: rtl/mbr_hs.sv
// mbr_hs: memory buffer register with a req/ack memory handshake.
// A read, write or ACC load is launched from IDLE by a one-hot strobe on {C12,C11,C3}.
// Illegal strobes and strobes that arrive while busy are dropped and reported on cmd_err.
// With TIMEOUT>0, a transfer that sees no ack within TIMEOUT cycles is aborted.
// Optional build macro MBR_PARITY_EN adds even parity on the memory data path.
module mbr_hs #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              C3,
  input  logic              C11,
  input  logic              C12,
  input  logic [DATA_W-1:0] ACC_in,
  output logic [DATA_W-1:0] MBR_out,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              cmd_err,
`ifdef MBR_PARITY_EN
  input  logic              mem_rpar,
  output logic              mem_wpar,
  output logic              parity_err,
`endif
  output logic              timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  strb;
  logic        expire_c;

  assign strb = {C12, C11, C3};
  assign busy = (state != IDLE);

  // Wait-cycle counter; expire_c flags the last permitted cycle without an ack.
  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [CNT_W-1:0] cnt;

      // Count wait cycles without ack; idle holds the counter at zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (state == IDLE) begin
          cnt <= '0;
        end else if (!mem_ack) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign expire_c = (state != IDLE) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign expire_c = 1'b0;
    end
  endgenerate

  // Handshake FSM with registered buffer, memory-side outputs and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      MBR_out     <= '0;
      mem_wdata   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MBR_PARITY_EN
      mem_wpar    <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      cmd_err     <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MBR_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          case (strb)
            3'b000: ;
            3'b001: begin
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
              state   <= RD_WAIT;
            end
            3'b010: begin
              mem_wdata <= MBR_out;
`ifdef MBR_PARITY_EN
              mem_wpar  <= ^MBR_out;
`endif
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              state     <= WR_WAIT;
            end
            3'b100: begin
              MBR_out <= ACC_in;
              done    <= 1'b1;
            end
            default: cmd_err <= 1'b1;
          endcase
        end
        RD_WAIT: begin
          if (strb != 3'b000) cmd_err <= 1'b1;
          if (mem_ack) begin
            MBR_out <= mem_rdata;
            mem_req <= 1'b0;
            done    <= 1'b1;
`ifdef MBR_PARITY_EN
            parity_err <= (^mem_rdata) != mem_rpar;
`endif
            state   <= IDLE;
          end else if (expire_c) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        WR_WAIT: begin
          if (strb != 3'b000) cmd_err <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            state   <= IDLE;
          end else if (expire_c) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
